// File: rtl/simm_pkg.sv
// Shared types and default timing for the burst-capable FPM DRAM SIMM controller.
package simm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ROW,
    COL,
    BPRE,
    HOLD,
    PRE,
    REF_CAS,
    REF_RAS,
    REF_PRE
  } state_t;

  localparam int unsigned DEF_T_RCD            = 1;
  localparam int unsigned DEF_T_CAS            = 2;
  localparam int unsigned DEF_T_RAS_REF        = 3;
  localparam int unsigned DEF_T_RP             = 2;
  localparam int unsigned DEF_REFRESH_INTERVAL = 250;

  // Phase down-counter width; every timing parameter must fit below 2**CNT_W.
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned BEAT_W      = 2;
  localparam int unsigned BURST_BEATS = 4;

endpackage

// File: rtl/simm_refresh_timer.sv
// Free-running refresh interval counter with pending request and sticky overrun flag.
module simm_refresh_timer
  import simm_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic clock,
  input  logic reset,
  input  logic ack,
  output logic pending,
  output logic overrun
);

  localparam int unsigned CW = $clog2(REFRESH_INTERVAL + 1);

  logic [CW-1:0] count;
  logic          tick;
  logic          pend_q;

  assign tick = (count == CW'(REFRESH_INTERVAL - 1));

  // The tick is visible in its own cycle so refresh wins a tie with a new access.
  assign pending = pend_q | tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      pend_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      count  <= tick ? '0 : count + CW'(1);
      pend_q <= (pend_q | tick) & ~ack;
      if (tick && pend_q && !ack) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/simm_controller_burst.sv
// FPM DRAM SIMM controller: per-bank RAS, per-lane CAS, 68030 4-beat bursts and CBR refresh.
module simm_controller_burst
  import simm_pkg::*;
#(
  parameter int unsigned NUM_BANKS        = 4,
  parameter int unsigned BANK_BITS        = $clog2(NUM_BANKS),
  parameter int unsigned LANES            = 4,
  parameter int unsigned T_RCD            = DEF_T_RCD,
  parameter int unsigned T_CAS            = DEF_T_CAS,
  parameter int unsigned T_RAS_REF        = DEF_T_RAS_REF,
  parameter int unsigned T_RP             = DEF_T_RP,
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 as,
  input  logic                 ds,
  input  logic                 rn_w,
  input  logic [BANK_BITS-1:0] bank_addr,
  input  logic [LANES-1:0]     byte_selects,
  input  logic                 burst_req,
  input  logic [1:0]           col_lsb_in,
  output logic                 write,
  output logic [NUM_BANKS-1:0] ras,
  output logic [LANES-1:0]     cas,
  output logic                 waitstate,
  output logic                 mux_select,
  output logic [1:0]           col_lsb,
  output logic                 burst_ack,
  output logic                 refresh_busy,
  output logic                 refresh_overrun
);

  // With a one-cycle CAS phase the ready beat is also the entry cycle.
  localparam logic READY_ON_ENTRY = (T_CAS == 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BEAT_W-1:0] beat;
  logic [LANES-1:0]  bsel_q;
  logic              burst_q;
  logic              ref_pending;
  logic              ref_ack_c;
  logic              unused_ds;

  // Early write puts data on the bus before CAS, so ds carries no timing.
  assign unused_ds = ds;

  assign ref_ack_c = (state == IDLE) && ref_pending;

  simm_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clock  (clock),
    .reset  (reset),
    .ack    (ref_ack_c),
    .pending(ref_pending),
    .overrun(refresh_overrun)
  );

  // Outputs are registered and updated on the transition into the state that owns them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      beat         <= '0;
      bsel_q       <= '0;
      burst_q      <= 1'b0;
      write        <= 1'b0;
      ras          <= '0;
      cas          <= '0;
      waitstate    <= 1'b1;
      mux_select   <= 1'b0;
      col_lsb      <= 2'd0;
      burst_ack    <= 1'b0;
      refresh_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_pending) begin
            state        <= REF_CAS;
            cas          <= '1;
            refresh_busy <= 1'b1;
          end else if (cs && as) begin
            state      <= ROW;
            cnt        <= CNT_W'(T_RCD - 1);
            beat       <= '0;
            bsel_q     <= byte_selects;
            burst_q    <= burst_req;
            write      <= rn_w;
            ras        <= NUM_BANKS'(1) << bank_addr;
            mux_select <= 1'b0;
            col_lsb    <= col_lsb_in;
          end
        end

        ROW: begin
          if (cnt == '0) begin
            state      <= COL;
            cnt        <= CNT_W'(T_CAS - 1);
            mux_select <= 1'b1;
            cas        <= write ? bsel_q : '1;
            if (READY_ON_ENTRY) begin
              waitstate <= 1'b0;
              burst_ack <= burst_q;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        COL: begin
          if (cnt == '0) begin
            if (burst_q && (beat != BEAT_W'(BURST_BEATS - 1))) begin
              state     <= BPRE;
              beat      <= beat + BEAT_W'(1);
              cas       <= '0;
              waitstate <= 1'b1;
              col_lsb   <= col_lsb + 2'd1;
            end else begin
              state     <= HOLD;
              burst_ack <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              waitstate <= 1'b0;
              burst_ack <= burst_q;
            end
          end
        end

        BPRE: begin
          state <= COL;
          cnt   <= CNT_W'(T_CAS - 1);
          cas   <= write ? bsel_q : '1;
          if (READY_ON_ENTRY) begin
            waitstate <= 1'b0;
          end
        end

        HOLD: begin
          if (!as) begin
            state      <= PRE;
            cnt        <= CNT_W'(T_RP - 1);
            write      <= 1'b0;
            ras        <= '0;
            cas        <= '0;
            waitstate  <= 1'b1;
            mux_select <= 1'b0;
            col_lsb    <= 2'd0;
            burst_ack  <= 1'b0;
          end
        end

        PRE: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        REF_CAS: begin
          state <= REF_RAS;
          cnt   <= CNT_W'(T_RAS_REF - 1);
          ras   <= '1;
        end

        REF_RAS: begin
          if (cnt == '0) begin
            state <= REF_PRE;
            cnt   <= CNT_W'(T_RP - 1);
            ras   <= '0;
            cas   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        REF_PRE: begin
          if (cnt == '0) begin
            state        <= IDLE;
            refresh_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simm_controller_burst.sv
// Directed bench for simm_controller_burst: refresh cadence, read/write, burst, collision, overrun and reset.
module tb_simm_controller_burst;

  logic       clock;
  logic       reset;
  logic       cs;
  logic       as;
  logic       ds;
  logic       rn_w;
  logic [1:0] bank_addr;
  logic [3:0] byte_selects;
  logic       burst_req;
  logic [1:0] col_lsb_in;
  logic       write;
  logic [3:0] ras;
  logic [3:0] cas;
  logic       waitstate;
  logic       mux_select;
  logic [1:0] col_lsb;
  logic       burst_ack;
  logic       refresh_busy;
  logic       refresh_overrun;

  int tests_run;
  int tests_failed;

  simm_controller_burst dut (
    .clock          (clock),
    .reset          (reset),
    .cs             (cs),
    .as             (as),
    .ds             (ds),
    .rn_w           (rn_w),
    .bank_addr      (bank_addr),
    .byte_selects   (byte_selects),
    .burst_req      (burst_req),
    .col_lsb_in     (col_lsb_in),
    .write          (write),
    .ras            (ras),
    .cas            (cas),
    .waitstate      (waitstate),
    .mux_select     (mux_select),
    .col_lsb        (col_lsb),
    .burst_ack      (burst_ack),
    .refresh_busy   (refresh_busy),
    .refresh_overrun(refresh_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    cs           = 1'b0;
    as           = 1'b0;
    ds           = 1'b0;
    rn_w         = 1'b0;
    bank_addr    = 2'd0;
    byte_selects = 4'd0;
    burst_req    = 1'b0;
    col_lsb_in   = 2'd0;
  endtask

  task automatic do_reset();
    bus_idle();
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_write"}, 32'(write), 32'd0);
    check({pfx, "_ras"}, 32'(ras), 32'd0);
    check({pfx, "_cas"}, 32'(cas), 32'd0);
    check({pfx, "_waitstate"}, 32'(waitstate), 32'd1);
    check({pfx, "_mux"}, 32'(mux_select), 32'd0);
    check({pfx, "_col_lsb"}, 32'(col_lsb), 32'd0);
    check({pfx, "_burst_ack"}, 32'(burst_ack), 32'd0);
    check({pfx, "_busy"}, 32'(refresh_busy), 32'd0);
    check({pfx, "_overrun"}, 32'(refresh_overrun), 32'd0);
  endtask

  // Burst read expectations for edges 1..13 (col_lsb_in = 2).
  logic       exp_ws  [1:13];
  logic [1:0] exp_col [1:13];
  logic       exp_ack [1:13];
  logic [3:0] exp_cas [1:13];

  initial begin
    exp_ws  = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    exp_col = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 1, 1, 1};
    exp_ack = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    exp_cas = '{4'h0, 4'hf, 4'hf, 4'h0, 4'hf, 4'hf, 4'h0, 4'hf, 4'hf, 4'h0, 4'hf, 4'hf, 4'hf};
  end

  initial begin
    int   last_start;
    int   nref;
    int   run;
    logic [3:0] prev_ras;
    logic [3:0] prev_cas;
    logic       prev_busy;
    logic       found;

    tests_run    = 0;
    tests_failed = 0;

    // Reset values, then a long idle stretch with periodic refresh.
    do_reset();
    check_reset_values("rst");
    last_start = -1;
    nref       = 0;
    run        = 0;
    prev_ras   = 4'h0;
    prev_cas   = 4'h0;
    prev_busy  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (refresh_busy && !prev_busy) begin
        if (last_start < 0) check("ref_first_start", 32'(i), 32'd249);
        else check("ref_interval", 32'(i - last_start), 32'd250);
        last_start = i;
        nref++;
      end
      if (ras == 4'hf && prev_ras == 4'h0) begin
        check("ref_cas_before_ras", 32'(prev_cas), 32'hf);
        run = 1;
      end else if (ras == 4'hf) begin
        run++;
      end
      if (ras == 4'h0 && prev_ras == 4'hf) check("ref_ras_len", 32'(run), 32'd3);
      if (waitstate !== 1'b1) check("ref_idle_waitstate", 32'(waitstate), 32'd1);
      prev_ras  = ras;
      prev_cas  = cas;
      prev_busy = refresh_busy;
    end
    check("ref_count", 32'(nref), 32'd12);
    check("ref_no_overrun", 32'(refresh_overrun), 32'd0);

    // Single read, bank 0, lanes 1010, followed by a back-to-back access.
    do_reset();
    cs = 1'b1; as = 1'b1; rn_w = 1'b0; bank_addr = 2'd0; byte_selects = 4'b1010;
    step();
    check("rd_e1_ras", 32'(ras), 32'h1);
    check("rd_e1_mux", 32'(mux_select), 32'd0);
    check("rd_e1_cas", 32'(cas), 32'h0);
    check("rd_e1_write", 32'(write), 32'd0);
    cs = 1'b0;
    step();
    check("rd_e2_mux", 32'(mux_select), 32'd1);
    check("rd_e2_cas", 32'(cas), 32'hf);
    check("rd_e2_ws", 32'(waitstate), 32'd1);
    step();
    check("rd_e3_ws", 32'(waitstate), 32'd0);
    step();
    step();
    check("rd_hold_ws", 32'(waitstate), 32'd0);
    check("rd_hold_ras", 32'(ras), 32'h1);
    check("rd_hold_cas", 32'(cas), 32'hf);
    as = 1'b0;
    step();
    check("rd_pre1_ras", 32'(ras), 32'h0);
    check("rd_pre1_cas", 32'(cas), 32'h0);
    check("rd_pre1_ws", 32'(waitstate), 32'd1);
    check("rd_pre1_mux", 32'(mux_select), 32'd0);
    cs = 1'b1; as = 1'b1;
    step();
    check("rd_pre2_ras", 32'(ras), 32'h0);
    step();
    check("rd_b2b_idle_ras", 32'(ras), 32'h0);
    step();
    check("rd_b2b_row_ras", 32'(ras), 32'h1);
    bus_idle();
    repeat (10) step();
    check("rd_b2b_done_ras", 32'(ras), 32'h0);

    // Single write, bank 1, lanes 0011.
    do_reset();
    cs = 1'b1; as = 1'b1; rn_w = 1'b1; bank_addr = 2'd1; byte_selects = 4'b0011;
    step();
    check("wr_e1_write", 32'(write), 32'd1);
    check("wr_e1_ras", 32'(ras), 32'h2);
    cs = 1'b0;
    step();
    check("wr_e2_cas", 32'(cas), 32'h3);
    check("wr_e2_write", 32'(write), 32'd1);
    step();
    check("wr_e3_ws", 32'(waitstate), 32'd0);
    check("wr_e3_cas", 32'(cas), 32'h3);
    as = 1'b0;
    step();
    step();
    check("wr_pre_write", 32'(write), 32'd0);
    check("wr_pre_cas", 32'(cas), 32'h0);
    repeat (3) step();

    // Four-beat burst read starting at column 2.
    do_reset();
    cs = 1'b1; as = 1'b1; rn_w = 1'b0; bank_addr = 2'd0; byte_selects = 4'b1111;
    burst_req = 1'b1; col_lsb_in = 2'd2;
    for (int e = 1; e <= 13; e++) begin
      step();
      cs = 1'b0;
      check($sformatf("bu_e%0d_ws", e), 32'(waitstate), 32'(exp_ws[e]));
      check($sformatf("bu_e%0d_col", e), 32'(col_lsb), 32'(exp_col[e]));
      check($sformatf("bu_e%0d_ack", e), 32'(burst_ack), 32'(exp_ack[e]));
      check($sformatf("bu_e%0d_cas", e), 32'(cas), 32'(exp_cas[e]));
      check($sformatf("bu_e%0d_ras", e), 32'(ras), 32'h1);
    end
    bus_idle();
    step();
    step();
    check("bu_pre_ras", 32'(ras), 32'h0);
    repeat (3) step();

    // Access request arriving on the very edge refresh becomes pending.
    do_reset();
    repeat (249) step();
    cs = 1'b1; as = 1'b1; rn_w = 1'b0; bank_addr = 2'd0; byte_selects = 4'hf;
    step();
    check("col_refcas_busy", 32'(refresh_busy), 32'd1);
    check("col_refcas_cas", 32'(cas), 32'hf);
    check("col_refcas_ras", 32'(ras), 32'h0);
    step();
    check("col_refras1_ras", 32'(ras), 32'hf);
    step();
    step();
    check("col_refras3_ras", 32'(ras), 32'hf);
    check("col_refras3_ws", 32'(waitstate), 32'd1);
    step();
    check("col_refpre1_ras", 32'(ras), 32'h0);
    check("col_refpre1_cas", 32'(cas), 32'h0);
    check("col_refpre1_busy", 32'(refresh_busy), 32'd1);
    step();
    check("col_refpre2_busy", 32'(refresh_busy), 32'd1);
    step();
    check("col_idle_busy", 32'(refresh_busy), 32'd0);
    check("col_idle_ras", 32'(ras), 32'h0);
    step();
    check("col_row_ras", 32'(ras), 32'h1);
    bus_idle();
    repeat (10) step();

    // Starve refresh by holding as, then reset in the middle of COL.
    do_reset();
    cs = 1'b1; as = 1'b1; rn_w = 1'b0; bank_addr = 2'd0; byte_selects = 4'hf;
    repeat (499) step();
    check("ovr_before", 32'(refresh_overrun), 32'd0);
    step();
    check("ovr_set", 32'(refresh_overrun), 32'd1);
    repeat (10) step();
    check("ovr_hold_ws", 32'(waitstate), 32'd0);
    cs = 1'b0; as = 1'b0;
    step();
    cs = 1'b1; as = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (mux_select === 1'b1) found = 1'b1;
    end
    check("ovr_col_reached", 32'(found), 32'd1);
    check("ovr_sticky", 32'(refresh_overrun), 32'd1);
    check("ovr_col_cas", 32'(cas), 32'hf);
    reset = 1'b1;
    step();
    check_reset_values("midcol");
    reset = 1'b0;
    bus_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
